// File: rtl/cr_pkg.sv
// Shared CR definitions: standard encodings, bin-count lookup and mapper FSM states.
// Also used by the CR control/allocation register block.
package cr_pkg;
  localparam int NMAX_DEF = 4096;
  localparam int DW_DEF   = 32;
  localparam int IDX_W    = 12;

  typedef enum logic [1:0] {
    STD_128  = 2'b00,
    STD_512  = 2'b01,
    STD_4096 = 2'b10,
    STD_RSVD = 2'b11
  } cr_std_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    MAP   = 2'd2,
    DRAIN = 2'd3
  } cr_state_e;

  // Bins per symbol; zero marks the reserved encoding.
  function automatic logic [IDX_W:0] std_bins(input logic [1:0] std);
    logic [IDX_W:0] n;
    case (std)
      2'b00:   n = 13'd128;
      2'b01:   n = 13'd512;
      2'b10:   n = 13'd4096;
      default: n = 13'd0;
    endcase
    return n;
  endfunction
endpackage

// File: rtl/cr_subc_mapper_if.sv
// Bus bundle for the subcarrier mapper: allocation/standard inputs, sample input
// stream and IFFT-side output stream. master = surrounding system, slave = mapper.
interface cr_subc_mapper_if
  import cr_pkg::*;
#(
  parameter int NMAX = NMAX_DEF,
  parameter int DW   = DW_DEF
) ();
  logic [NMAX-1:0] ALLOC_VEC;
  logic [1:0]      STD;
  logic            VEC_LD;
  logic [DW-1:0]   DAT_I;
  logic            CYC_I;
  logic            STB_I;
  logic            ACK_O;
  logic [DW-1:0]   DAT_O;
  logic            CYC_O;
  logic            STB_O;
  logic            SOF_O;
  logic            ACK_I;

  modport master (
    output ALLOC_VEC, STD, DAT_I, CYC_I, STB_I, ACK_I,
    input  VEC_LD, ACK_O, DAT_O, CYC_O, STB_O, SOF_O
  );

  modport slave (
    input  ALLOC_VEC, STD, DAT_I, CYC_I, STB_I, ACK_I,
    output VEC_LD, ACK_O, DAT_O, CYC_O, STB_O, SOF_O
  );
endinterface

// File: rtl/cr_out_reg.sv
// One-deep registered output stage: holds a beat until the consumer accepts it,
// and can take a new beat on the same edge the held one is accepted.
module cr_out_reg #(
  parameter int DW = 32
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic          load,
  input  logic [DW-1:0] dat,
  input  logic          sof,
  input  logic          ack,
  output logic [DW-1:0] dat_o,
  output logic          stb_o,
  output logic          sof_o
);
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      dat_o <= '0;
      stb_o <= 1'b0;
      sof_o <= 1'b0;
    end else if (load) begin
      dat_o <= dat;
      stb_o <= 1'b1;
      sof_o <= sof;
    end else if (ack) begin
      stb_o <= 1'b0;
      sof_o <= 1'b0;
    end
  end
endmodule

// File: rtl/cr_subc_mapper.sv
// Per-symbol subcarrier mapper: snapshots the allocation vector and standard, then
// emits N bins, taking an input sample for each allocated bin and zero otherwise.
module cr_subc_mapper
  import cr_pkg::*;
#(
  parameter int NMAX = NMAX_DEF,
  parameter int DW   = DW_DEF
) (
  input logic              CLK_I,
  input logic              RST_I,
  cr_subc_mapper_if.slave  bus
);
  cr_state_e        state;
  logic [NMAX-1:0]  shadow;
  logic [IDX_W-1:0] idx;
  logic [IDX_W:0]   n_bins;
  logic             vec_ld;
  logic             cyc_o;
  logic             stb_o;

  logic             out_rdy;
  logic             cur_bit;
  logic             take;
  logic             do_load;
  logic             last_bin;
  logic             start_ok;
  logic             drained;
  logic [DW-1:0]    load_dat;

  assign out_rdy  = !stb_o || bus.ACK_I;
  assign cur_bit  = shadow[idx];
  assign take     = cur_bit && bus.CYC_I && bus.STB_I;
  // Allocated bin waits for a sample while the stream is up; once it drops, bins flush as zero.
  assign do_load  = (state == MAP) && out_rdy && (!cur_bit || !bus.CYC_I || bus.STB_I);
  assign load_dat = take ? bus.DAT_I : '0;
  assign last_bin = ({1'b0, idx} == (n_bins - 1'b1));
  assign start_ok = bus.CYC_I && (bus.STD != STD_RSVD);
  assign drained  = (state == DRAIN) && stb_o && bus.ACK_I;

  assign bus.ACK_O  = do_load && take;
  assign bus.VEC_LD = vec_ld;
  assign bus.CYC_O  = cyc_o;
  assign bus.STB_O  = stb_o;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state  <= IDLE;
      shadow <= '0;
      idx    <= '0;
      n_bins <= '0;
      vec_ld <= 1'b0;
      cyc_o  <= 1'b0;
    end else begin
      vec_ld <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            state  <= LOAD;
            vec_ld <= 1'b1;
            cyc_o  <= 1'b1;
          end
        end
        LOAD: begin
          shadow <= bus.ALLOC_VEC;
          n_bins <= std_bins(bus.STD);
          idx    <= '0;
          // STD moved to reserved between request and snapshot: abandon the symbol.
          if (std_bins(bus.STD) == '0) begin
            state <= IDLE;
            cyc_o <= 1'b0;
          end else begin
            state <= MAP;
          end
        end
        MAP: begin
          if (do_load) begin
            if (last_bin) state <= DRAIN;
            else          idx   <= idx + 1'b1;
          end
        end
        DRAIN: begin
          if (drained) begin
            if (start_ok) begin
              state  <= LOAD;
              vec_ld <= 1'b1;
            end else begin
              state <= IDLE;
              cyc_o <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  cr_out_reg #(.DW(DW)) u_out (
    .CLK_I (CLK_I),
    .RST_I (RST_I),
    .load  (do_load),
    .dat   (load_dat),
    .sof   (idx == '0),
    .ack   (bus.ACK_I),
    .dat_o (bus.DAT_O),
    .stb_o (stb_o),
    .sof_o (bus.SOF_O)
  );
endmodule

// File: tb/tb_cr_subc_mapper.sv
// Randomized self-checking bench for cr_subc_mapper against a per-symbol bin model.
module tb_cr_subc_mapper;
  localparam int NMAX = 4096;
  localparam int DW   = 32;

  logic CLK_I = 1'b0;
  logic RST_I = 1'b1;
  always #5 CLK_I = ~CLK_I;

  cr_subc_mapper_if #(.NMAX(NMAX), .DW(DW)) bus ();

  cr_subc_mapper #(.NMAX(NMAX), .DW(DW)) dut (
    .CLK_I (CLK_I),
    .RST_I (RST_I),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] src [0:NMAX-1];
  logic [DW-1:0] got_dat [$];
  logic          got_sof [$];
  logic [DW-1:0] exp_q   [$];
  int n_in, n_vld, hold_bad, cyc_gap;

  task automatic fill_src();
    for (int i = 0; i < NMAX; i++) src[i] = $urandom;
  endtask

  // Reference: walk the bins in order; allocated bins consume the next available sample.
  task automatic build_exp(input int n, input logic [NMAX-1:0] alloc, input int avail);
    int p;
    p = 0;
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      if (alloc[k] && p < avail) begin exp_q.push_back(src[p]); p++; end
      else exp_q.push_back('0);
    end
  endtask

  function automatic int cnt_alloc(input int n, input logic [NMAX-1:0] alloc);
    int c;
    c = 0;
    for (int k = 0; k < n; k++) if (alloc[k]) c++;
    return c;
  endfunction

  // Drives one symbol and records outputs; limit = samples offered before CYC_I drops.
  task automatic drive_sym(input logic [1:0] std, input logic [NMAX-1:0] alloc, input int limit,
                           input int stb_pct, input int ack_pct, input int stop_beats);
    logic          held;
    logic [DW-1:0] held_dat;
    logic          drop;
    got_dat.delete(); got_sof.delete();
    n_in = 0; n_vld = 0; hold_bad = 0; cyc_gap = 0; held = 1'b0; held_dat = '0;
    bus.ALLOC_VEC = alloc;
    bus.STD       = std;
    bus.CYC_I     = 1'b1;
    bus.STB_I     = ($urandom % 100) < stb_pct;
    bus.DAT_I     = src[0];
    bus.ACK_I     = ($urandom % 100) < ack_pct;
    for (int cyc = 0; cyc < 20000 && got_dat.size() < stop_beats; cyc++) begin
      @(negedge CLK_I);
      if (held && (!bus.STB_O || bus.DAT_O !== held_dat)) hold_bad++;
      held     = bus.STB_O && !bus.ACK_I;
      held_dat = bus.DAT_O;
      if (bus.VEC_LD) n_vld++;
      if (n_vld > 0 && !bus.CYC_O) cyc_gap++;
      if (bus.STB_O && bus.ACK_I) begin got_dat.push_back(bus.DAT_O); got_sof.push_back(bus.SOF_O); end
      if (bus.STB_I && bus.ACK_O) n_in++;
      @(posedge CLK_I); #1;
      drop      = (n_vld > 0) && (n_in >= limit);
      bus.CYC_I = !drop;
      bus.STB_I = !drop && (($urandom % 100) < stb_pct);
      bus.DAT_I = (n_in < NMAX) ? src[n_in] : '0;
      bus.ACK_I = ($urandom % 100) < ack_pct;
    end
  endtask

  task automatic idle_gap();
    bus.CYC_I = 1'b0; bus.STB_I = 1'b0; bus.ACK_I = 1'b1;
    repeat (3) @(negedge CLK_I);
  endtask

  task automatic test_reset();
    bus.ALLOC_VEC = '0; bus.STD = 2'b00; bus.DAT_I = '0;
    bus.CYC_I = 1'b0; bus.STB_I = 1'b0; bus.ACK_I = 1'b0;
    RST_I = 1'b1;
    #12;
    total++; if (bus.VEC_LD !== 1'b0) begin bad++; $display("FAIL rst_vec_ld got=%b want=0", bus.VEC_LD); end
    total++; if (bus.CYC_O !== 1'b0)  begin bad++; $display("FAIL rst_cyc_o got=%b want=0", bus.CYC_O); end
    total++; if (bus.STB_O !== 1'b0)  begin bad++; $display("FAIL rst_stb_o got=%b want=0", bus.STB_O); end
    total++; if (bus.SOF_O !== 1'b0)  begin bad++; $display("FAIL rst_sof_o got=%b want=0", bus.SOF_O); end
    total++; if (bus.DAT_O !== '0)    begin bad++; $display("FAIL rst_dat_o got=%h want=0", bus.DAT_O); end
    @(negedge CLK_I); RST_I = 1'b0;
    idle_gap();
  endtask

  task automatic test_alternate();
    logic [NMAX-1:0] a;
    int nb;
    a = '1;
    for (int k = 0; k < 128; k++) a[k] = (k % 2 == 0);
    fill_src(); build_exp(128, a, NMAX);
    drive_sym(2'b00, a, cnt_alloc(128, a), 100, 100, 128);
    @(negedge CLK_I);
    total++; if (got_dat.size() != 128) begin bad++; $display("FAIL alt_beats got=%0d want=128", got_dat.size()); end
    nb = 0;
    for (int i = 0; i < got_dat.size(); i++) begin
      total++;
      if (got_dat[i] !== exp_q[i] || got_sof[i] !== (i == 0)) begin
        bad++; nb++;
        if (nb < 8) $display("FAIL alt_beat[%0d] got=%h sof=%b want=%h sof=%b", i, got_dat[i], got_sof[i], exp_q[i], i == 0);
      end
    end
    total++; if (n_in != 64)   begin bad++; $display("FAIL alt_acks got=%0d want=64", n_in); end
    total++; if (n_vld != 1)   begin bad++; $display("FAIL alt_vec_ld got=%0d want=1", n_vld); end
    total++; if (cyc_gap != 0) begin bad++; $display("FAIL alt_cyc_gap got=%0d want=0", cyc_gap); end
    total++; if (bus.CYC_O !== 1'b0 || bus.STB_O !== 1'b0)
      begin bad++; $display("FAIL alt_end got cyc=%b stb=%b want 0 0", bus.CYC_O, bus.STB_O); end
    idle_gap();
  endtask

  task automatic test_zero_alloc();
    logic [NMAX-1:0] a;
    int nz;
    a = '0; a[NMAX-1:128] = '1;
    fill_src();
    drive_sym(2'b00, a, 0, 100, 100, 128);
    @(negedge CLK_I);
    nz = 0;
    for (int i = 0; i < got_dat.size(); i++) if (got_dat[i] !== '0) nz++;
    total++; if (got_dat.size() != 128) begin bad++; $display("FAIL zero_beats got=%0d want=128", got_dat.size()); end
    total++; if (nz != 0)    begin bad++; $display("FAIL zero_data nonzero=%0d want=0", nz); end
    total++; if (n_in != 0)  begin bad++; $display("FAIL zero_acks got=%0d want=0", n_in); end
    total++; if (n_vld != 1) begin bad++; $display("FAIL zero_vec_ld got=%0d want=1", n_vld); end
    total++; if (bus.CYC_O !== 1'b0) begin bad++; $display("FAIL zero_end cyc got=%b want=0", bus.CYC_O); end
    idle_gap();
  endtask

  task automatic test_full_random_ack();
    logic [NMAX-1:0] a;
    int nb;
    a = '1;
    fill_src(); build_exp(512, a, NMAX);
    drive_sym(2'b01, a, 512, 80, 50, 512);
    @(negedge CLK_I);
    total++; if (got_dat.size() != 512) begin bad++; $display("FAIL full_beats got=%0d want=512", got_dat.size()); end
    nb = 0;
    for (int i = 0; i < got_dat.size(); i++) begin
      total++;
      if (got_dat[i] !== exp_q[i]) begin
        bad++; nb++;
        if (nb < 8) $display("FAIL full_beat[%0d] got=%h want=%h", i, got_dat[i], exp_q[i]);
      end
    end
    total++; if (n_in != 512)   begin bad++; $display("FAIL full_acks got=%0d want=512", n_in); end
    total++; if (hold_bad != 0) begin bad++; $display("FAIL full_hold got=%0d want=0", hold_bad); end
    total++; if (n_vld != 1)    begin bad++; $display("FAIL full_vec_ld got=%0d want=1", n_vld); end
    total++; if (bus.CYC_O !== 1'b0) begin bad++; $display("FAIL full_end cyc got=%b want=0", bus.CYC_O); end
    idle_gap();
  endtask

  task automatic test_random_alloc();
    logic [NMAX-1:0] a;
    int nb;
    for (int k = 0; k < NMAX; k++) a[k] = $urandom_range(1, 0);
    fill_src(); build_exp(128, a, NMAX);
    drive_sym(2'b00, a, cnt_alloc(128, a), 70, 70, 128);
    @(negedge CLK_I);
    total++; if (got_dat.size() != 128) begin bad++; $display("FAIL ralloc_beats got=%0d want=128", got_dat.size()); end
    nb = 0;
    for (int i = 0; i < got_dat.size(); i++) begin
      total++;
      if (got_dat[i] !== exp_q[i]) begin
        bad++; nb++;
        if (nb < 8) $display("FAIL ralloc_beat[%0d] got=%h want=%h", i, got_dat[i], exp_q[i]);
      end
    end
    total++; if (n_in != cnt_alloc(128, a)) begin bad++; $display("FAIL ralloc_acks got=%0d want=%0d", n_in, cnt_alloc(128, a)); end
    total++; if (hold_bad != 0) begin bad++; $display("FAIL ralloc_hold got=%0d want=0", hold_bad); end
    idle_gap();
  endtask

  task automatic test_flush();
    logic [NMAX-1:0] a;
    int nb;
    a = '1;
    fill_src(); build_exp(128, a, 40);
    drive_sym(2'b00, a, 40, 100, 100, 128);
    @(negedge CLK_I);
    total++; if (got_dat.size() != 128) begin bad++; $display("FAIL flush_beats got=%0d want=128", got_dat.size()); end
    nb = 0;
    for (int i = 0; i < got_dat.size(); i++) begin
      total++;
      if (got_dat[i] !== exp_q[i]) begin
        bad++; nb++;
        if (nb < 8) $display("FAIL flush_beat[%0d] got=%h want=%h", i, got_dat[i], exp_q[i]);
      end
    end
    total++; if (n_in != 40) begin bad++; $display("FAIL flush_acks got=%0d want=40", n_in); end
    total++; if (bus.CYC_O !== 1'b0) begin bad++; $display("FAIL flush_end cyc got=%b want=0", bus.CYC_O); end
    idle_gap();
  endtask

  task automatic test_reserved();
    int v, a, s, c;
    v = 0; a = 0; s = 0; c = 0;
    bus.ALLOC_VEC = '1; bus.STD = 2'b11;
    bus.CYC_I = 1'b1; bus.STB_I = 1'b1; bus.ACK_I = 1'b1; bus.DAT_I = 32'hdead_beef;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK_I);
      if (bus.VEC_LD) v++;
      if (bus.ACK_O)  a++;
      if (bus.STB_O)  s++;
      if (bus.CYC_O)  c++;
    end
    total++; if (v != 0) begin bad++; $display("FAIL rsvd_vec_ld got=%0d want=0", v); end
    total++; if (a != 0) begin bad++; $display("FAIL rsvd_ack got=%0d want=0", a); end
    total++; if (s != 0) begin bad++; $display("FAIL rsvd_stb got=%0d want=0", s); end
    total++; if (c != 0) begin bad++; $display("FAIL rsvd_cyc got=%0d want=0", c); end
    idle_gap();
  endtask

  task automatic test_reset_mid();
    logic [NMAX-1:0] a;
    int nb;
    a = '1;
    fill_src();
    drive_sym(2'b00, a, 128, 100, 100, 60);
    total++; if (got_dat.size() != 60) begin bad++; $display("FAIL rmid_pre_beats got=%0d want=60", got_dat.size()); end
    RST_I = 1'b1;
    #1;
    total++; if (bus.STB_O !== 1'b0) begin bad++; $display("FAIL rmid_stb got=%b want=0", bus.STB_O); end
    total++; if (bus.CYC_O !== 1'b0) begin bad++; $display("FAIL rmid_cyc got=%b want=0", bus.CYC_O); end
    total++; if (bus.DAT_O !== '0)   begin bad++; $display("FAIL rmid_dat got=%h want=0", bus.DAT_O); end
    total++; if (bus.ACK_O !== 1'b0) begin bad++; $display("FAIL rmid_ack got=%b want=0", bus.ACK_O); end
    @(negedge CLK_I); @(negedge CLK_I);
    RST_I = 1'b0;
    fill_src(); build_exp(128, a, NMAX);
    drive_sym(2'b00, a, 128, 100, 100, 128);
    @(negedge CLK_I);
    total++; if (n_vld != 1) begin bad++; $display("FAIL rmid_vec_ld got=%0d want=1", n_vld); end
    total++; if (got_dat.size() != 128) begin bad++; $display("FAIL rmid_beats got=%0d want=128", got_dat.size()); end
    nb = 0;
    for (int i = 0; i < got_dat.size(); i++) begin
      total++;
      if (got_dat[i] !== exp_q[i] || got_sof[i] !== (i == 0)) begin
        bad++; nb++;
        if (nb < 8) $display("FAIL rmid_beat[%0d] got=%h sof=%b want=%h sof=%b", i, got_dat[i], got_sof[i], exp_q[i], i == 0);
      end
    end
    idle_gap();
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_zero_alloc();
    test_full_random_ack();
    test_random_alloc();
    test_flush();
    test_reserved();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
